// File: rtl/bf_row_loader_pkg.sv
// Shared constants and state encoding for the Bellman-Ford row loader.
package bf_row_loader_pkg;

  localparam int DEF_LANES    = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_NUM_ROWS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bf_row_loader_if.sv
// Host stream, processing-block and row-memory signals of the row loader.
interface bf_row_loader_if
  import bf_row_loader_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic                    load_req;
  logic                    host_valid;
  logic [DATA_W-1:0]       host_data;
  logic                    host_ready;
  logic                    pb_start;
  logic                    pb_finish;
  logic                    pb_write_enable;
  logic [ADDR_W-1:0]       pb_write_address;
  logic [LANES*DATA_W-1:0] pb_wdata;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [LANES*DATA_W-1:0] mem_wdata;
  logic                    busy;
  logic                    done;

  modport slave (
    input  load_req, host_valid, host_data, pb_finish,
           pb_write_enable, pb_write_address, pb_wdata,
    output host_ready, pb_start, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport master (
    output load_req, host_valid, host_data, pb_finish,
           pb_write_enable, pb_write_address, pb_wdata,
    input  host_ready, pb_start, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/bf_row_loader_packer.sv
// Collects LANES accepted words into one row buffer; lane 0 holds the first word.
module bf_row_packer
  import bf_row_loader_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_global,
  input  logic                    accept,
  input  logic [DATA_W-1:0]       word,
  input  logic                    clear,
  output logic                    row_full,
  output logic [LANES*DATA_W-1:0] row_data
);
  localparam int LW = cnt_w(LANES);

  logic [LW-1:0] lane_q, lane_d;
  logic          lane_last;

  assign lane_last = (lane_q == LW'(LANES - 1));
  assign row_full  = accept & lane_last;

  always_comb begin
    lane_d = lane_q;
    if (clear) begin
      lane_d = '0;
    end else if (accept) begin
      lane_d = lane_last ? '0 : lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_global) begin
    if (!rst_global) lane_q <= '0;
    else             lane_q <= lane_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] word_q;

      always_ff @(posedge clk or negedge rst_global) begin
        if (!rst_global) begin
          word_q <= '0;
        end else if (accept && (lane_q == LW'(gi))) begin
          word_q <= word;
        end
      end

      assign row_data[gi*DATA_W +: DATA_W] = word_q;
    end
  endgenerate

endmodule

// File: rtl/bf_row_loader.sv
// Loads host words into the row memory row by row, starts the processing
// block, then lends it the memory write port until it finishes.
module bf_row_loader
  import bf_row_loader_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_ROWS = DEF_NUM_ROWS
) (
  input  logic         clk,
  input  logic         rst_global,
  bf_row_loader_if.slave bus
);
  localparam int RW = cnt_w(NUM_ROWS);

  state_e                  state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic                    clear;
  logic                    row_full;
  logic                    row_last;
  logic [LANES*DATA_W-1:0] row_data;

  assign accept   = bus.host_valid & (state_q == ST_LOAD);
  assign clear    = (state_q == ST_IDLE) & bus.load_req;
  assign row_last = (row_q == RW'(NUM_ROWS - 1));

  bf_row_packer #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .rst_global (rst_global),
    .accept     (accept),
    .word       (bus.host_data),
    .clear      (clear),
    .row_full   (row_full),
    .row_data   (row_data)
  );

  always_ff @(posedge clk or negedge rst_global) begin
    if (!rst_global) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_req) begin
          state_d = ST_LOAD;
          row_d   = '0;
        end
      end
      ST_LOAD: begin
        if (row_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (row_last) begin
          state_d = ST_START;
        end else begin
          state_d = ST_LOAD;
          row_d   = row_q + 1'b1;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.pb_finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outside RUN the memory port shows the loader's own row counter and buffer.
  always_comb begin
    bus.host_ready = 1'b0;
    bus.pb_start   = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = ADDR_W'(row_q);
    bus.mem_wdata  = row_data;
    bus.busy       = (state_q != ST_IDLE);
    bus.done       = done_q;
    case (state_q)
      ST_LOAD:  bus.host_ready = 1'b1;
      ST_WRITE: bus.mem_we     = 1'b1;
      ST_START: bus.pb_start   = 1'b1;
      ST_RUN: begin
        bus.mem_we    = bus.pb_write_enable;
        bus.mem_addr  = bus.pb_write_address;
        bus.mem_wdata = bus.pb_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bf_row_loader.sv
// Directed self-checking bench for bf_row_loader.
module tb_bf_row_loader;
  import bf_row_loader_pkg::*;

  localparam int L  = DEF_LANES;
  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;
  localparam int NR = DEF_NUM_ROWS;
  localparam int RB = L * DW;

  typedef struct {
    logic we;
    int   addr;
    int   base;
    logic exp_we;
    int   exp_addr;
    int   exp_base;
  } run_vec_t;

  logic clk = 1'b0;
  logic rst_global = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bf_row_loader_if #(.LANES(L), .DATA_W(DW), .ADDR_W(AW)) bus ();

  bf_row_loader #(
    .LANES(L), .DATA_W(DW), .ADDR_W(AW), .NUM_ROWS(NR)
  ) dut (
    .clk        (clk),
    .rst_global (rst_global),
    .bus        (bus.slave)
  );

  task automatic chk(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RB-1:0] row_of(input int base);
    logic [RB-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) r[k*DW +: DW] = DW'(base + k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".host_ready"}, RB'(bus.host_ready), '0);
    chk({tag, ".pb_start"},   RB'(bus.pb_start), '0);
    chk({tag, ".mem_we"},     RB'(bus.mem_we), '0);
    chk({tag, ".mem_addr"},   RB'(bus.mem_addr), '0);
    chk({tag, ".mem_wdata"},  bus.mem_wdata, '0);
    chk({tag, ".busy"},       RB'(bus.busy), '0);
    chk({tag, ".done"},       RB'(bus.done), '0);
  endtask

  // Runs one load from IDLE up to the first RUN cycles; words are first..first+63.
  task automatic do_job(input string tag, input int first, input bit bursty, input bit noise);
    int            sent = 0;
    int            first_acc = -1;
    int            start_cyc = -1;
    int            nwr = 0;
    logic          ready_bad = 1'b0;
    logic [AW-1:0] wa [NR];
    logic [RB-1:0] wd [NR];
    bus.load_req = 1'b1;
    #1;
    chk({tag, ".idle_busy"}, RB'(bus.busy), '0);
    tick();
    bus.load_req = 1'b0;
    for (int cyc = 0; cyc < 400 && start_cyc < 0; cyc++) begin
      bus.host_valid = (sent < NR * L) && (!bursty || (cyc % 2 == 0));
      bus.host_data  = DW'(first + sent);
      bus.pb_finish  = noise && ((cyc / 2) % 2 == 1);
      #1;
      if (bus.host_valid && bus.host_ready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      if (bus.mem_we) begin
        if (nwr < NR) begin
          wa[nwr] = bus.mem_addr;
          wd[nwr] = bus.mem_wdata;
        end
        nwr++;
        if (bus.host_ready) ready_bad = 1'b1;
      end
      if (bus.pb_start) start_cyc = cyc;
      tick();
    end
    bus.host_valid = 1'b0;
    bus.pb_finish  = 1'b0;
    chk({tag, ".start_seen"}, RB'(start_cyc >= 0), RB'(1));
    chk({tag, ".words"}, RB'(sent), RB'(NR * L));
    chk({tag, ".writes"}, RB'(nwr), RB'(NR));
    for (int r = 0; r < NR; r++) begin
      if (r < nwr) begin
        $display("%s: write row %0d addr=%0d", tag, r, wa[r]);
        chk($sformatf("%s.addr%0d", tag, r), RB'(wa[r]), RB'(r));
        chk($sformatf("%s.data%0d", tag, r), wd[r], row_of(first + r * L));
      end
    end
    chk({tag, ".ready_in_write"}, RB'(ready_bad), '0);
    if (!bursty)
      chk({tag, ".start_latency"}, RB'(start_cyc - first_acc + 1), RB'(NR * (L + 1) + 1));
    bus.host_valid = 1'b1;
    bus.load_req   = noise;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("%s.run_ready%0d", tag, i), RB'(bus.host_ready), '0);
      chk($sformatf("%s.run_start%0d", tag, i), RB'(bus.pb_start), '0);
      chk($sformatf("%s.run_busy%0d", tag, i),  RB'(bus.busy), RB'(1));
      tick();
    end
    bus.host_valid = 1'b0;
    bus.load_req   = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    bus.pb_write_enable = 1'b0;
    bus.pb_finish = 1'b1;
    #1;
    chk({tag, ".pre_done"}, RB'(bus.done), '0);
    chk({tag, ".pre_busy"}, RB'(bus.busy), RB'(1));
    tick();
    bus.pb_finish = 1'b0;
    bus.pb_write_enable = 1'b1;
    #1;
    chk({tag, ".done"}, RB'(bus.done), RB'(1));
    chk({tag, ".busy"}, RB'(bus.busy), '0);
    chk({tag, ".idle_we"}, RB'(bus.mem_we), '0);
    $display("%s: done pulse, busy=%0b", tag, bus.busy);
    tick();
    bus.pb_write_enable = 1'b0;
    #1;
    chk({tag, ".done_clr"}, RB'(bus.done), '0);
  endtask

  run_vec_t tv [4];

  initial begin
    tv[0] = '{we: 1'b1, addr: 5,    base: 'hA0, exp_we: 1'b1, exp_addr: 5,    exp_base: 'hA0};
    tv[1] = '{we: 1'b0, addr: 5,    base: 'hA0, exp_we: 1'b0, exp_addr: 5,    exp_base: 'hA0};
    tv[2] = '{we: 1'b1, addr: 1023, base: 'h10, exp_we: 1'b1, exp_addr: 1023, exp_base: 'h10};
    tv[3] = '{we: 1'b1, addr: 0,    base: 'h55, exp_we: 1'b1, exp_addr: 0,    exp_base: 'h55};

    bus.load_req = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_data = '0;
    bus.pb_finish = 1'b0;
    bus.pb_write_enable = 1'b0;
    bus.pb_write_address = '0;
    bus.pb_wdata = '0;
    #12;
    chk_all_zero("reset");
    $display("reset: outputs checked");

    bus.load_req = 1'b0;
    bus.host_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_global = 1'b1;
    tick();
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.host_valid = 1'b1;
      bus.host_data = DW'(i);
      tick();
    end
    bus.host_valid = 1'b0;
    #2;
    rst_global = 1'b0;
    #1;
    chk_all_zero("mid_load_reset");
    $display("mid_load_reset: outputs checked");
    tick();
    rst_global = 1'b1;
    tick();

    do_job("after_reset", 64, 1'b0, 1'b0);
    finish_job("after_reset_fin");

    do_job("continuous", 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.pb_write_enable  = tv[i].we;
      bus.pb_write_address = AW'(tv[i].addr);
      bus.pb_wdata         = row_of(tv[i].base);
      #1;
      chk($sformatf("run_mux%0d.we", i),   RB'(bus.mem_we), RB'(tv[i].exp_we));
      chk($sformatf("run_mux%0d.addr", i), RB'(bus.mem_addr), RB'(tv[i].exp_addr));
      chk($sformatf("run_mux%0d.data", i), bus.mem_wdata, row_of(tv[i].exp_base));
      $display("run_mux%0d: we=%0b addr=%0d", i, bus.mem_we, bus.mem_addr);
      tick();
    end
    bus.pb_write_enable = 1'b0;
    bus.pb_wdata = '0;
    finish_job("continuous_fin");

    do_job("bursty", 0, 1'b1, 1'b1);
    finish_job("bursty_fin");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
